registro_disparos: RTL

- Downstream consumer of the coordinate decoder. Takes the 6-bit cell index X produced from row L and column C, plus a fire request.
- Checks the shot against a fixed ship map and a history bitmap of cells already shot.
- Classifies each shot as MISS, HIT, REPEAT or INVALID, keeps the hit and shot counters, and declares game over when every ship cell has been hit.

---
 rtl/disparo_pkg.sv | 37 +++
 rtl/classifica_disparo.sv | 23 ++
 rtl/registro_disparos.sv | 139 +++++++++++++
 3 files changed

// File: rtl/disparo_pkg.sv
// Shared result codes, FSM states and elaboration helpers
// for the shot register (registro_disparos).
package disparo_pkg;

  localparam logic [1:0] RES_MISS    = 2'b00;
  localparam logic [1:0] RES_HIT     = 2'b01;
  localparam logic [1:0] RES_REPEAT  = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RESULT,
    ST_FIM
  } state_e;

  function automatic logic [6:0] popcount64(
    input logic [63:0] v
  );
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++)
      cnt = cnt + 7'(v[i]);
    return cnt;
  endfunction

  function automatic logic [63:0] cell_mask(
    input int n
  );
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/classifica_disparo.sv
// Combinational shot classifier: INVALID > REPEAT > HIT > MISS.
module classifica_disparo
  import disparo_pkg::*;
#(
  parameter int          NUM_CELLS = 36,
  parameter logic [63:0] SHIP_MAP  = 64'h0000_0000_0F00_3C07
) (
  input  logic [5:0]  i_cell,
  input  logic [63:0] i_shot_map,
  output logic [1:0]  o_result
);

  always_comb begin
    o_result = RES_MISS;
    if (int'(i_cell) >= NUM_CELLS)
      o_result = RES_INVALID;
    else if (i_shot_map[i_cell])
      o_result = RES_REPEAT;
    else if (SHIP_MAP[i_cell])
      o_result = RES_HIT;
  end

endmodule

// File: rtl/registro_disparos.sv
// Battleship shot register: classifies shots, counts hits/shots.
// Optional shot budget enabled with `define SHOT_LIMIT_EN.
module registro_disparos
  import disparo_pkg::*;
#(
  parameter int          NUM_CELLS = 36,
  parameter logic [63:0] SHIP_MAP  = 64'h0000_0000_0F00_3C07,
  parameter int          MAX_SHOTS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] cell_in,
  input  logic       fire_valid,
  output logic       fire_ready,
  input  logic       new_game,
  output logic       result_valid,
  output logic [1:0] result,
  output logic [5:0] hit_count,
  output logic [6:0] shot_count,
  output logic       game_over,
`ifdef SHOT_LIMIT_EN
  output logic       lose,
  output logic [6:0] shots_left
`else
  output logic       lose
`endif
);

  localparam logic [6:0] SHIP_TOTAL =
    popcount64(SHIP_MAP & cell_mask(NUM_CELLS));

  state_e      r_state;
  state_e      w_next;
  logic [5:0]  r_cell;
  logic [63:0] r_shot_map;
  logic [1:0]  r_result;
  logic [5:0]  r_hits;
  logic [6:0]  r_shots;
  logic [1:0]  w_class;
  logic        w_won;
  logic        w_lost;
  logic        w_count;

  classifica_disparo #(
    .NUM_CELLS (NUM_CELLS),
    .SHIP_MAP  (SHIP_MAP)
  ) u_class (
    .i_cell     (r_cell),
    .i_shot_map (r_shot_map),
    .o_result   (w_class)
  );

  assign w_won = ({1'b0, r_hits} == SHIP_TOTAL);
  assign w_count = (w_class == RES_HIT) ||
                   (w_class == RES_MISS);

`ifdef SHOT_LIMIT_EN
  logic r_lose;
  assign w_lost = !w_won &&
                  (r_shots == 7'(MAX_SHOTS));
  assign lose = r_lose;
  assign shots_left = 7'(MAX_SHOTS) - r_shots;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lose <= 1'b0;
    else if (new_game)
      r_lose <= 1'b0;
    else if (r_state == ST_RESULT && w_lost)
      r_lose <= 1'b1;
  end
`else
  assign w_lost = 1'b0;
  assign lose = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // new_game overrides every state, including an in-flight shot
  always_comb begin
    w_next = r_state;
    if (new_game) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:
          if (fire_valid) w_next = ST_CHECK;
        ST_CHECK:
          w_next = ST_RESULT;
        ST_RESULT:
          w_next = (w_won || w_lost) ? ST_FIM : ST_IDLE;
        ST_FIM:
          w_next = ST_FIM;
        default:
          w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cell     <= '0;
      r_shot_map <= '0;
      r_result   <= RES_MISS;
      r_hits     <= '0;
      r_shots    <= '0;
    end else if (new_game) begin
      r_shot_map <= '0;
      r_hits     <= '0;
      r_shots    <= '0;
    end else begin
      if (r_state == ST_IDLE && fire_valid)
        r_cell <= cell_in;
      if (r_state == ST_CHECK) begin
        r_result <= w_class;
        if (w_count) begin
          r_shot_map[r_cell] <= 1'b1;
          if (r_shots != 7'h7f)
            r_shots <= r_shots + 7'd1;
        end
        if (w_class == RES_HIT)
          r_hits <= r_hits + 6'd1;
      end
    end
  end

  assign fire_ready   = (r_state == ST_IDLE);
  assign result_valid = (r_state == ST_RESULT);
  assign game_over    = (r_state == ST_FIM);
  assign result       = r_result;
  assign hit_count    = r_hits;
  assign shot_count   = r_shots;

endmodule
